// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared sizing helpers and arbitration mode encodings for mem_port_arbiter
package mem_arb_pkg;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int BYTE_W    = 8;

    function automatic int port_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int byte_lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational pick over a request vector, rotating from ptr_i or fixed lowest-index-first
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           fixed_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] id_o
);
    logic [IDW-1:0] idx;

    // Scan from lowest priority to highest so the last hit is the winner
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = fixed_i ? IDW'(k) : IDW'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: multiplexes NUM_PORTS request channels onto one memory port
// with round-robin/fixed arbitration, stall-locked grants and one pipelined outstanding access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_PORTS-1:0]              req_valid,
    output logic [NUM_PORTS-1:0]              req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0]   req_we,
    input  logic [NUM_PORTS*DATA_W-1:0]       req_wdata,
    output logic [NUM_PORTS-1:0]              resp_valid,
    output logic [DATA_W-1:0]                 resp_rdata,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W/8-1:0]               mem_we,
    output logic                              mem_re,
    output logic [DATA_W-1:0]                 mem_din,
    input  logic [DATA_W-1:0]                 mem_dout,
    input  logic                              mem_stall
);
    localparam int IDW = port_id_w(NUM_PORTS);
    localparam int BL  = byte_lanes(DATA_W);

    logic [NUM_PORTS-1:0] arb_gnt;
    logic [IDW-1:0]       arb_id, gid;
    logic [IDW-1:0]       pend_id_q, pend_id_d, lock_id_q, lock_id_d, rr_ptr_q, rr_ptr_d;
    logic                 pend_q, pend_d, locked_q, locked_d;
    logic                 gvalid, accept, resp;
    logic [BL-1:0]        g_we;

    rr_arbiter #(.N(NUM_PORTS), .IDW(IDW)) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .fixed_i (FIXED_PRIO == ARB_FIXED),
        .gnt_o   (arb_gnt),
        .id_o    (arb_id)
    );

    // A stalled grant stays pinned to its port so the memory sees a stable request
    always_comb begin
        gid        = locked_q ? lock_id_q : arb_id;
        gvalid     = reset_n && (locked_q ? req_valid[lock_id_q] : |arb_gnt);
        g_we       = req_we[gid*BL +: BL];
        mem_addr   = gvalid ? req_addr[gid*ADDR_W +: ADDR_W] : '0;
        mem_din    = gvalid ? req_wdata[gid*DATA_W +: DATA_W] : '0;
        mem_we     = gvalid ? g_we : '0;
        mem_re     = gvalid && (g_we == '0);
        accept     = gvalid && !mem_stall;
        resp       = pend_q && !mem_stall;
        req_ready  = accept ? NUM_PORTS'(1) << gid : '0;
        resp_valid = resp ? NUM_PORTS'(1) << pend_id_q : '0;
        resp_rdata = mem_dout;
        pend_d     = accept || (pend_q && !resp);
        pend_id_d  = accept ? gid : pend_id_q;
        locked_d   = !accept && (locked_q || (gvalid && mem_stall));
        lock_id_d  = (gvalid && mem_stall) ? gid : lock_id_q;
        rr_ptr_d   = (accept && FIXED_PRIO == ARB_RR && NUM_PORTS > 1)
                   ? ((gid == IDW'(NUM_PORTS - 1)) ? '0 : gid + 1'b1) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= 1'b0;
            pend_id_q <= '0;
            locked_q  <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a behavioural model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_addr = '0;
    logic [7:0]  req_we = '0;
    logic [63:0] req_wdata = '0;
    logic [31:0] mem_dout = '0;
    logic        mem_stall = 1'b0;

    logic [1:0]  rr_ready, rr_resp, fx_ready, fx_resp;
    logic [31:0] rr_rdata, rr_addr, rr_din, fx_rdata, fx_addr, fx_din;
    logic [3:0]  rr_we, fx_we;
    logic        rr_re, fx_re;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] mem [logic [31:0]];
    logic [1:0]  must_hold;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rr_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .resp_valid(rr_resp), .resp_rdata(rr_rdata), .mem_addr(rr_addr), .mem_we(rr_we),
        .mem_re(rr_re), .mem_din(rr_din), .mem_dout(mem_dout), .mem_stall(mem_stall));

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) u_fx (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(fx_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .resp_valid(fx_resp), .resp_rdata(fx_rdata), .mem_addr(fx_addr), .mem_we(fx_we),
        .mem_re(fx_re), .mem_din(fx_din), .mem_dout(mem_dout), .mem_stall(mem_stall));

    // A request seen under stall must be held until the arbiter takes it
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) must_hold <= '0;
        else begin
            assert ((must_hold & ~req_valid) == 2'b00)
                else $error("FAIL hold_valid: dropped %b held %b", req_valid, must_hold);
            must_hold <= (must_hold | (mem_stall ? req_valid : 2'b00)) & ~rr_ready;
        end
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ({a[15:0], ~a[15:0]} ^ 32'h1357_9BDF);
    endfunction

    // Memory model: a read accepted this cycle returns its data after the edge and holds through stalls
    task automatic tick();
        logic acc;
        logic [31:0] a;
        acc = rr_re && !mem_stall && reset_n;
        a = rr_addr;
        @(posedge clk);
        #1;
        if (acc) mem_dout = mem_rd(a);
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        req_addr[p*32 +: 32] = a;
        req_we[p*4 +: 4] = we;
        req_wdata[p*32 +: 32] = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 2'b11;
        set_port(0, 32'h40, 4'h0, 0);
        set_port(1, 32'h44, 4'h0, 0);
        @(negedge clk);
        n_cmp++; if (rr_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", rr_ready); end
        n_cmp++; if (rr_re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", rr_re); end
        n_cmp++; if (rr_we !== 4'h0) begin n_fail++; $display("FAIL reset_we: got %h want 0", rr_we); end
        n_cmp++; if (rr_resp !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b want 00", rr_resp); end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        reset_n = 1'b1;
        @(negedge clk);
        tick();
    endtask

    task automatic test_single_read();
        mem[32'h100] = 32'hDEAD_BEEF;
        req_valid = 2'b10;
        set_port(1, 32'h100, 4'h0, 0);
        @(negedge clk);
        n_cmp++; if (rr_ready !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", rr_ready); end
        n_cmp++; if (rr_re !== 1'b1) begin n_fail++; $display("FAIL single_re_t: got %b want 1", rr_re); end
        n_cmp++; if (rr_addr !== 32'h100) begin n_fail++; $display("FAIL single_addr: got %h want 100", rr_addr); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (rr_resp !== 2'b10) begin n_fail++; $display("FAIL single_resp: got %b want 10", rr_resp); end
        n_cmp++; if (rr_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", rr_rdata); end
        n_cmp++; if (rr_re !== 1'b0) begin n_fail++; $display("FAIL single_re_t1: got %b want 0", rr_re); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        req_valid = 2'b11;
        set_port(0, 32'h10, 4'h0, 0);
        set_port(1, 32'h20, 4'h0, 0);
        for (int i = 0; i < 6; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_cmp++; if (rr_ready !== exp) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", i, rr_ready, exp); end
            n_cmp++; if (fx_ready !== 2'b01) begin n_fail++; $display("FAIL fixed_order[%0d]: got %b want 01", i, fx_ready); end
            tick();
        end
        req_valid = 2'b00;
        @(negedge clk);
        tick();
    endtask

    task automatic test_stall_lock();
        mem_stall = 1'b1;
        req_valid = 2'b10;
        set_port(1, 32'h200, 4'b0011, 32'h1234_5678);
        set_port(0, 32'h300, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) req_valid = 2'b11;
            @(negedge clk);
            n_cmp++; if (rr_addr !== 32'h200) begin n_fail++; $display("FAIL lock_addr[%0d]: got %h want 200", i, rr_addr); end
            n_cmp++; if (rr_we !== 4'b0011) begin n_fail++; $display("FAIL lock_we[%0d]: got %b want 0011", i, rr_we); end
            n_cmp++; if (rr_ready !== 2'b00) begin n_fail++; $display("FAIL lock_ready[%0d]: got %b want 00", i, rr_ready); end
            tick();
        end
        mem_stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (rr_ready !== 2'b10) begin n_fail++; $display("FAIL lock_first: got %b want 10", rr_ready); end
        n_cmp++; if (fx_ready !== 2'b10) begin n_fail++; $display("FAIL lock_first_fixed: got %b want 10", fx_ready); end
        n_cmp++; if (rr_din !== 32'h1234_5678) begin n_fail++; $display("FAIL lock_din: got %h want 12345678", rr_din); end
        tick();
        req_valid = 2'b01;
        @(negedge clk);
        n_cmp++; if (rr_ready !== 2'b01) begin n_fail++; $display("FAIL lock_second: got %b want 01", rr_ready); end
        n_cmp++; if (rr_resp !== 2'b10) begin n_fail++; $display("FAIL lock_write_ack: got %b want 10", rr_resp); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (rr_resp !== 2'b01) begin n_fail++; $display("FAIL lock_read_ack: got %b want 01", rr_resp); end
        tick();
    endtask

    task automatic back_pair(input logic [31:0] a, input logic [31:0] b, input int stall_len);
        req_valid = 2'b01;
        set_port(0, a, 4'h0, 0);
        @(negedge clk);
        n_cmp++; if (rr_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_acc_a: got %b want 01", rr_ready); end
        tick();
        set_port(0, b, 4'h0, 0);
        @(negedge clk);
        n_cmp++; if (rr_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_acc_b: got %b want 01", rr_ready); end
        n_cmp++; if (rr_resp !== 2'b01 || rr_rdata !== mem_rd(a))
            begin n_fail++; $display("FAIL b2b_resp_a: got %b/%h want 01/%h", rr_resp, rr_rdata, mem_rd(a)); end
        tick();
        req_valid = 2'b00;
        mem_stall = 1'b1;
        for (int i = 0; i < stall_len; i++) begin
            @(negedge clk);
            n_cmp++; if (rr_resp !== 2'b00) begin n_fail++; $display("FAIL b2b_stalled[%0d]: got %b want 00", i, rr_resp); end
            tick();
        end
        mem_stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (rr_resp !== 2'b01 || rr_rdata !== mem_rd(b))
            begin n_fail++; $display("FAIL b2b_resp_b: got %b/%h want 01/%h", rr_resp, rr_rdata, mem_rd(b)); end
        tick();
    endtask

    task automatic test_back_to_back();
        back_pair(32'h400, 32'h404, 0);
        back_pair(32'h500, 32'h504, 2);
    endtask

    task automatic test_reset_mid_access();
        req_valid = 2'b11;
        set_port(0, 32'h600, 4'h0, 0);
        set_port(1, 32'h700, 4'h0, 0);
        @(negedge clk);
        n_cmp++; if (rr_ready !== 2'b10) begin n_fail++; $display("FAIL rst_pre_grant: got %b want 10", rr_ready); end
        tick();
        reset_n = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (rr_resp !== 2'b00) begin n_fail++; $display("FAIL rst_resp_in: got %b want 00", rr_resp); end
        tick();
        reset_n = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        n_cmp++; if (rr_resp !== 2'b00) begin n_fail++; $display("FAIL rst_resp_out: got %b want 00", rr_resp); end
        n_cmp++; if (rr_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b want 01", rr_ready); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        tick();
    endtask

    task automatic test_random();
        logic        hv [2];
        logic [31:0] ha [2];
        logic [3:0]  hw [2];
        logic [31:0] hd [2];
        int ptr = 0, lk = 0, lk_id = 0, pend = 0, pend_id = 0, pend_rd = 0, g;
        logic [31:0] pend_a;
        logic [1:0]  e_ready, e_resp;
        for (int p = 0; p < 2; p++) hv[p] = 1'b0;
        reset_n = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 310; c++) begin
            for (int p = 0; p < 2; p++)
                if (!hv[p] && c < 300 && $urandom_range(0, 1) == 1) begin
                    hv[p] = 1'b1;
                    ha[p] = $urandom & 32'hFFFC;
                    hw[p] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                    hd[p] = $urandom;
                end
            for (int p = 0; p < 2; p++) begin
                req_valid[p] = hv[p];
                set_port(p, ha[p], hw[p], hd[p]);
            end
            mem_stall = (c < 300) && ($urandom_range(0, 3) == 0);
            g = -1;
            if (lk != 0) g = lk_id;
            else for (int k = 1; k >= 0; k--) if (hv[(ptr + k) % 2]) g = (ptr + k) % 2;
            e_ready = (g >= 0 && !mem_stall) ? 2'(1 << g) : 2'b00;
            e_resp = (pend != 0 && !mem_stall) ? 2'(1 << pend_id) : 2'b00;
            @(negedge clk);
            n_cmp++; if (rr_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, rr_ready, e_ready); end
            n_cmp++; if (rr_resp !== e_resp) begin n_fail++; $display("FAIL rnd_resp[%0d]: got %b want %b", c, rr_resp, e_resp); end
            n_cmp++; if (rr_addr !== (g >= 0 ? ha[g] : 32'h0))
                begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h grant %0d", c, rr_addr, g); end
            n_cmp++; if (rr_re !== (g >= 0 && hw[g] == 4'h0))
                begin n_fail++; $display("FAIL rnd_re[%0d]: got %b grant %0d", c, rr_re, g); end
            if (e_resp != 2'b00 && pend_rd != 0) begin
                n_cmp++; if (rr_rdata !== mem_rd(pend_a))
                    begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rr_rdata, mem_rd(pend_a)); end
            end
            if (g >= 0 && mem_stall) begin lk = 1; lk_id = g; end
            if (g >= 0 && !mem_stall) begin
                pend = 1; pend_id = g; pend_a = ha[g]; pend_rd = (hw[g] == 4'h0) ? 1 : 0;
                lk = 0; ptr = (g + 1) % 2; hv[g] = 1'b0;
            end else if (pend != 0 && !mem_stall) pend = 0;
            tick();
        end
        req_valid = 2'b00;
        mem_stall = 1'b0;
        n_cmp++; if (hv[0] || hv[1] || pend != 0) begin n_fail++; $display("FAIL rnd_drain: left %b%b pend %0d", hv[1], hv[0], pend); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_stall_lock();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
